// File: rtl/pwm_seq_pkg.sv
// Shared note-entry layout and state encoding for the PWM note sequencer.
// An entry is packed {dur, vol, n} with n in the low bits.
package pwm_seq_pkg;

   localparam int N_W     = 10;
   localparam int VOL_W   = 8;
   localparam int DUR_W   = 8;
   localparam int ENTRY_W = N_W + VOL_W + DUR_W;

   localparam int N_LSB   = 0;
   localparam int VOL_LSB = N_LSB + N_W;
   localparam int DUR_LSB = VOL_LSB + VOL_W;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_PLAY = 3'd2;
   localparam logic [2:0] ST_GAP  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      LOAD = ST_LOAD,
      PLAY = ST_PLAY,
      GAP  = ST_GAP,
      DONE = ST_DONE
   } seq_state_t;

endpackage

// File: rtl/pwm_note_sequencer_tick_prescaler.sv
// Duration tick generator: after clear, tick is high for one cycle at the end
// of every TICK_DIV-cycle period (TICK_DIV >= 2).
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);

   logic [CW-1:0] cnt_r;
   logic          tick_r;

   // Tick is registered one count early so it lines up with the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= {CW{1'b0}};
         tick_r <= 1'b0;
      end else if (clear) begin
         cnt_r  <= {CW{1'b0}};
         tick_r <= 1'b0;
      end else begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
         tick_r <= (cnt_r == CNT_PRE);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/pwm_note_sequencer.sv
// Note-table melody sequencer driving pwm_audio.N and pwm_audio.volume.
// Define ARTIC_GAP_EN to insert a silent GAP_TICKS articulation gap after every note.
module pwm_note_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int TICK_DIV  = 50000,
   parameter int GAP_TICKS = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [N_W-1:0]     N,
   output logic [VOL_W-1:0]   volume,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      note_idx
);

   logic [ENTRY_W-1:0] table_r [DEPTH];
   logic [ENTRY_W-1:0] rd_entry_r;
   seq_state_t         state_r;
   logic [N_W-1:0]     n_r;
   logic [VOL_W-1:0]   vol_r;
   logic               busy_r;
   logic               done_r;
   logic [AW-1:0]      note_idx_r;
   logic [DUR_W-1:0]   dur_cnt_r;
   logic [DUR_W-1:0]   dur_last_r;

   logic [N_W-1:0]     rd_n_s;
   logic [VOL_W-1:0]   rd_vol_s;
   logic [DUR_W-1:0]   rd_dur_s;
   logic               tick_s;
   logic               clear_s;
   logic               phase_end_s;
   logic               last_entry_s;
   logic               finish_s;
   logic [AW-1:0]      next_idx_s;

`ifdef ARTIC_GAP_EN
   localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);
`else
   logic unused_gap_s;
   assign unused_gap_s = ^GAP_TICKS;
`endif

   assign rd_n_s   = rd_entry_r[N_LSB +: N_W];
   assign rd_vol_s = rd_entry_r[VOL_LSB +: VOL_W];
   assign rd_dur_s = rd_entry_r[DUR_LSB +: DUR_W];

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_s),
      .tick  (tick_s)
   );

   // Timed-phase termination, next-entry choice and prescaler clear.
   always_comb begin
      phase_end_s  = tick_s && (dur_cnt_r == dur_last_r);
      last_entry_s = (note_idx_r == AW'(DEPTH - 1));
      finish_s     = last_entry_s && !loop;
      if (last_entry_s) begin
         next_idx_s = {AW{1'b0}};
      end else begin
         next_idx_s = note_idx_r + AW'(1);
      end
`ifdef ARTIC_GAP_EN
      if ((state_r == PLAY) || (state_r == GAP)) begin
`else
      if (state_r == PLAY) begin
`endif
         clear_s = phase_end_s;
      end else begin
         clear_s = 1'b1;
      end
   end

   // Host table writes land only while idle; reset leaves the contents intact.
   always_ff @(posedge clk) begin
      if (wr_en && !busy_r) begin
         table_r[wr_addr] <= wr_data;
      end
   end

   // Playback state machine with registered outputs toward pwm_audio.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         n_r        <= {N_W{1'b0}};
         vol_r      <= {VOL_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         note_idx_r <= {AW{1'b0}};
         rd_entry_r <= {ENTRY_W{1'b0}};
         dur_cnt_r  <= {DUR_W{1'b0}};
         dur_last_r <= {DUR_W{1'b0}};
      end else if (stop) begin
         state_r    <= IDLE;
         n_r        <= {N_W{1'b0}};
         vol_r      <= {VOL_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         note_idx_r <= {AW{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               n_r   <= {N_W{1'b0}};
               vol_r <= {VOL_W{1'b0}};
               if (start) begin
                  state_r    <= LOAD;
                  busy_r     <= 1'b1;
                  note_idx_r <= {AW{1'b0}};
                  rd_entry_r <= table_r[{AW{1'b0}}];
               end
            end
            LOAD: begin
               if (rd_dur_s == {DUR_W{1'b0}}) begin
                  state_r <= DONE;
                  n_r     <= {N_W{1'b0}};
                  vol_r   <= {VOL_W{1'b0}};
                  done_r  <= 1'b1;
               end else begin
                  state_r    <= PLAY;
                  n_r        <= rd_n_s;
                  vol_r      <= (rd_n_s == {N_W{1'b0}}) ? {VOL_W{1'b0}} : rd_vol_s;
                  dur_cnt_r  <= {DUR_W{1'b0}};
                  dur_last_r <= rd_dur_s - DUR_W'(1);
               end
            end
            PLAY: begin
               if (phase_end_s) begin
`ifdef ARTIC_GAP_EN
                  state_r    <= GAP;
                  vol_r      <= {VOL_W{1'b0}};
                  dur_cnt_r  <= {DUR_W{1'b0}};
                  dur_last_r <= GAP_LAST;
`else
                  if (finish_s) begin
                     state_r <= DONE;
                     n_r     <= {N_W{1'b0}};
                     vol_r   <= {VOL_W{1'b0}};
                     done_r  <= 1'b1;
                  end else begin
                     state_r    <= LOAD;
                     note_idx_r <= next_idx_s;
                     rd_entry_r <= table_r[next_idx_s];
                  end
`endif
               end else if (tick_s) begin
                  dur_cnt_r <= dur_cnt_r + DUR_W'(1);
               end
            end
`ifdef ARTIC_GAP_EN
            GAP: begin
               if (phase_end_s) begin
                  if (finish_s) begin
                     state_r <= DONE;
                     n_r     <= {N_W{1'b0}};
                     vol_r   <= {VOL_W{1'b0}};
                     done_r  <= 1'b1;
                  end else begin
                     state_r    <= LOAD;
                     note_idx_r <= next_idx_s;
                     rd_entry_r <= table_r[next_idx_s];
                  end
               end else if (tick_s) begin
                  dur_cnt_r <= dur_cnt_r + DUR_W'(1);
               end
            end
`endif
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               n_r     <= {N_W{1'b0}};
               vol_r   <= {VOL_W{1'b0}};
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               n_r     <= {N_W{1'b0}};
               vol_r   <= {VOL_W{1'b0}};
            end
         endcase
      end
   end

   assign N        = n_r;
   assign volume   = vol_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign note_idx = note_idx_r;

endmodule
